column_scheduler: RTL and testbench
===================================

# column_scheduler

Game controller that sequences a bank of falling-letter columns for the DE0 typing game. It owns the global fall tick, spawns new letters into idle columns round-robin, and routes each keystroke to the column whose letter it matches. It also keeps the score and speed level and declares game over when any column lands. It sits between the keyboard decoder and the column instances, whose `ypos` outputs drive the display.

## Interface
- `NUM_COLUMNS`, 4: number of column instances driven.
- `BASE_PERIOD`, 50_000_000: fall-tick period in clocks at level 0.
- `PERIOD_STEP`, 4_000_000: period reduction per level.
- `MIN_PERIOD`, 10_000_000: floor for the fall period.
- `SPAWN_TICKS`, 3: fall ticks between spawn attempts.
- `POINTS_PER_LEVEL`, 8: score increments per level-up.

Ports:
- `clock` in 1: system clock. One clock domain only.
- `reset_signal_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse. Starts a game from IDLE or OVER.
- `key_valid` in 1: one-cycle strobe; `key_code` is valid in that cycle.
- `key_code` in 8: ASCII of the key pressed.
- `col_active` in NUM_COLUMNS: column holds a falling letter.
- `col_landed` in NUM_COLUMNS: column has reached the bottom row.
- `col_letter` in 8*NUM_COLUMNS: current letter of each column; column i is at bits [8i+7:8i].
- `fall_tick` out 1: one-cycle pulse; columns advance one row.
- `col_spawn` out NUM_COLUMNS: one-hot, one-cycle pulse; the column loads `spawn_letter` and starts at row 0.
- `spawn_letter` out 8: ASCII 'A'..'Z'.
- `col_clear` out NUM_COLUMNS: one-cycle pulse; the column goes idle.
- `score` out 10: saturates at 1023.
- `level` out 4: saturates at 15.
- `game_over` out 1: high while in state OVER.

## Operation
- States:
  - IDLE: waiting for a game. `start` → RUN.
  - RUN: game in progress. Any `col_landed` bit → OVER.
  - OVER: game ended. `start` → RUN.
- On every entry to RUN:
  - `col_clear` = all ones for one cycle.
  - `score`, `level`, tick counter and spawn counter are zeroed.
- Fall period = max(BASE_PERIOD − level·PERIOD_STEP, MIN_PERIOD). The tick counter is 26 bits.
- `fall_tick` pulses each time the counter reaches period−1, and only in RUN.
- Spawn counter counts fall ticks. At SPAWN_TICKS it resets to 0 and makes a spawn attempt.
- Spawn attempt:
  - Search starts at the index after the last spawned column and wraps modulo NUM_COLUMNS.
  - The first column with `col_active`=0 receives `col_spawn`.
  - If all columns are active, the attempt is skipped; no retry until the next attempt.
- Letter source: 8-bit LFSR, polynomial x^8+x^6+x^5+x^4+1, nonzero seed 8'hA5, advanced every clock.
  - Take the low 5 bits; if ≥26, subtract 26.
  - Add 8'h41. Result is 'A'..'Z'.
- Keystroke in RUN: compare `key_code` with each active column's letter.
  - The lowest matching index gets `col_clear`; `score` += 1.
  - No match: no action.
  - At most one column is cleared per keystroke.
- Every POINTS_PER_LEVEL points, `level` += 1. Once saturated, `level` holds.
- Keystrokes outside RUN are ignored.

## Timing
- Reset values: state IDLE; all outputs 0; `spawn_letter` 8'h41; LFSR 8'hA5.
- `col_clear` for a match is registered: it appears the cycle after `key_valid`. `score` updates in that same cycle.
- `col_spawn` and `spawn_letter` are registered and asserted together, one cycle after the fall tick that triggers the spawn.
- `game_over` rises the cycle after a `col_landed` is sampled.
- Simultaneous events:
  - Landing and a match in the same cycle: landing wins. Go to OVER; no clear, no score.
  - A match and a spawn targeting the same column: the clear is issued; the spawn moves to the next free column in the same cycle, or is skipped if none is free.
  - `start` during RUN: ignored.
- Asynchronous reset mid-game: returns to IDLE immediately. Outputs are 0 from the reset edge.

## Structure
- Shared package `column_pkg` holds:
  - the state enum (IDLE, RUN, OVER);
  - `ASCII_A` = 8'h41 and `LETTER_COUNT` = 26;
  - `LFSR_SEED` = 8'hA5.
- Sub-module `letter_lfsr` contains the LFSR and the ASCII mapping. Output: `letter[7:0]`.
- Match priority, spawn round-robin and period calculation stay in `column_scheduler`.

## Test plan
Bench parameters: BASE_PERIOD=10, PERIOD_STEP=2, MIN_PERIOD=4, SPAWN_TICKS=2, POINTS_PER_LEVEL=2, NUM_COLUMNS=4.
- Reset release, then `start`:
  - All-ones `col_clear` pulse.
  - `fall_tick` every 10 clocks.
  - First `col_spawn`=4'b0001 one cycle after the 2nd tick; `spawn_letter` is in 'A'..'Z'.
- Columns 1 and 3 active, both with letter 'K'; `key_valid` with 'K' → `col_clear`=4'b0010 on the next cycle; `score`=1.
- 2 correct keys → `level`=1 and period 8. 10 more correct keys → period stays at 4.
- All 4 columns active at a spawn attempt → no `col_spawn`; the next attempt after one column clears spawns into that column.
- `col_landed`[2] and a matching key in the same cycle → `game_over`=1 next cycle; `score` unchanged; `fall_tick` stops. `start` → RUN with `score`=0.
- `reset_signal_n` low mid-RUN → all outputs 0 immediately, state IDLE; `key_valid` ignored until `start`.

Source files
------------

// File: rtl/column_pkg.sv
// column_pkg: shared types and constants for the falling-letter column scheduler.
// Provides the game state enum, the ASCII letter range and the letter LFSR seed.
package column_pkg;
   typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
   localparam logic [7:0] ASCII_A      = 8'h41;
   localparam int         LETTER_COUNT = 26;
   localparam logic [7:0] LFSR_SEED    = 8'hA5;
endpackage

// File: rtl/letter_lfsr.sv
// letter_lfsr: free-running 8-bit LFSR (x^8+x^6+x^5+x^4+1) mapped to an ASCII letter 'A'..'Z'.
// Ports: clock, reset_signal_n (async active-low), letter[7:0] (letter for the current LFSR state).
module letter_lfsr
   import column_pkg::*;
(
   input  logic       clock,
   input  logic       reset_signal_n,
   output logic [7:0] letter
);
   logic [7:0] lfsr_q, lfsr_d;
   logic [4:0] low;
   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      // Fold 26..31 back into range so every state maps onto a letter.
      low    = (lfsr_q[4:0] >= 5'(LETTER_COUNT)) ? lfsr_q[4:0] - 5'(LETTER_COUNT) : lfsr_q[4:0];
      letter = ASCII_A + {3'b000, low};
   end
   always_ff @(posedge clock or negedge reset_signal_n)
      if (!reset_signal_n) lfsr_q <= LFSR_SEED;
      else                 lfsr_q <= lfsr_d;
endmodule

// File: rtl/column_scheduler.sv
// column_scheduler: game controller for the falling-letter typing game.
// Ports: clock, reset_signal_n (async active-low), start, key_valid/key_code (keystroke),
//   col_active/col_landed/col_letter (column status), fall_tick, col_spawn, spawn_letter,
//   col_clear (column commands), score, level, game_over (game status). All outputs registered.
module column_scheduler
   import column_pkg::*;
#(
   parameter int NUM_COLUMNS      = 4,
   parameter int BASE_PERIOD      = 50_000_000,
   parameter int PERIOD_STEP      = 4_000_000,
   parameter int MIN_PERIOD       = 10_000_000,
   parameter int SPAWN_TICKS      = 3,
   parameter int POINTS_PER_LEVEL = 8
)
(
   input  logic                     clock,
   input  logic                     reset_signal_n,
   input  logic                     start,
   input  logic                     key_valid,
   input  logic [7:0]               key_code,
   input  logic [NUM_COLUMNS-1:0]   col_active,
   input  logic [NUM_COLUMNS-1:0]   col_landed,
   input  logic [8*NUM_COLUMNS-1:0] col_letter,
   output logic                     fall_tick,
   output logic [NUM_COLUMNS-1:0]   col_spawn,
   output logic [7:0]               spawn_letter,
   output logic [NUM_COLUMNS-1:0]   col_clear,
   output logic [9:0]               score,
   output logic [3:0]               level,
   output logic                     game_over
);
   localparam int CW = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
   localparam int SW = $clog2(SPAWN_TICKS + 1);
   localparam int PW = $clog2(POINTS_PER_LEVEL + 1);

   state_t                 state_q, state_d;
   logic [25:0]            tick_cnt_q, tick_cnt_d, period;
   logic [SW-1:0]          spawn_cnt_q, spawn_cnt_d;
   logic [PW-1:0]          pts_q, pts_d;
   logic [CW-1:0]          last_q, last_d, idx;
   logic [9:0]             score_q, score_d;
   logic [3:0]             level_q, level_d;
   logic                   fall_tick_q, fall_tick_d, game_over_q, game_over_d;
   logic [NUM_COLUMNS-1:0] col_spawn_q, col_spawn_d, col_clear_q, col_clear_d, hit, free;
   logic [7:0]             spawn_letter_q, spawn_letter_d, letter;
   logic                   hit_found, sp_found, tick_now, spawn_now, level_wrap;
   int                     dec;

   letter_lfsr u_lfsr (.clock(clock), .reset_signal_n(reset_signal_n), .letter(letter));

   always_comb begin
      dec    = int'(level_q) * PERIOD_STEP;
      period = (BASE_PERIOD - dec > MIN_PERIOD) ? 26'(BASE_PERIOD - dec) : 26'(MIN_PERIOD);
   end

   // Lowest-index active column whose letter matches the key.
   always_comb begin
      hit       = '0;
      hit_found = 1'b0;
      for (int i = 0; i < NUM_COLUMNS; i++)
         if (!hit_found && col_active[i] && col_letter[8*i +: 8] == key_code) begin
            hit[i]    = 1'b1;
            hit_found = 1'b1;
         end
   end

   always_comb begin
      state_d        = state_q;
      tick_cnt_d     = tick_cnt_q;
      spawn_cnt_d    = spawn_cnt_q;
      pts_d          = pts_q;
      last_d         = last_q;
      score_d        = score_q;
      level_d        = level_q;
      fall_tick_d    = 1'b0;
      col_spawn_d    = '0;
      col_clear_d    = '0;
      spawn_letter_d = spawn_letter_q;
      sp_found       = 1'b0;
      idx            = '0;
      // ">=" lets a shrinking period take effect even if the counter is already past it.
      tick_now       = tick_cnt_q >= period - 26'd1;
      spawn_now      = fall_tick_q && spawn_cnt_q == SW'(SPAWN_TICKS - 1);
      level_wrap     = pts_q == PW'(POINTS_PER_LEVEL - 1);
      // A column being cleared this cycle is never a spawn target.
      free           = ~col_active & ~(key_valid ? hit : '0);
      if (state_q != RUN) begin
         if (start) begin
            state_d     = RUN;
            col_clear_d = '1;
            tick_cnt_d  = '0;
            spawn_cnt_d = '0;
            pts_d       = '0;
            score_d     = '0;
            level_d     = '0;
         end
      end else if (|col_landed) begin
         state_d = OVER;
      end else begin
         tick_cnt_d  = tick_now ? '0 : tick_cnt_q + 26'd1;
         fall_tick_d = tick_now;
         if (key_valid && hit_found) begin
            col_clear_d = hit;
            if (score_q != '1) begin
               score_d = score_q + 10'd1;
               pts_d   = level_wrap ? '0 : pts_q + 1'b1;
               level_d = (level_wrap && level_q != '1) ? level_q + 4'd1 : level_q;
            end
         end
         if (fall_tick_q) spawn_cnt_d = spawn_now ? '0 : spawn_cnt_q + 1'b1;
         if (spawn_now)
            for (int k = 1; k <= NUM_COLUMNS; k++) begin
               idx = CW'((int'(last_q) + k) % NUM_COLUMNS);
               if (!sp_found && free[idx]) begin
                  sp_found         = 1'b1;
                  col_spawn_d[idx] = 1'b1;
                  last_d           = idx;
                  spawn_letter_d   = letter;
               end
            end
      end
      game_over_d = state_d == OVER;
   end

   always_ff @(posedge clock or negedge reset_signal_n)
      if (!reset_signal_n) begin
         state_q        <= IDLE;
         tick_cnt_q     <= '0;
         spawn_cnt_q    <= '0;
         pts_q          <= '0;
         last_q         <= CW'(NUM_COLUMNS - 1);
         score_q        <= '0;
         level_q        <= '0;
         fall_tick_q    <= 1'b0;
         col_spawn_q    <= '0;
         col_clear_q    <= '0;
         spawn_letter_q <= ASCII_A;
         game_over_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         tick_cnt_q     <= tick_cnt_d;
         spawn_cnt_q    <= spawn_cnt_d;
         pts_q          <= pts_d;
         last_q         <= last_d;
         score_q        <= score_d;
         level_q        <= level_d;
         fall_tick_q    <= fall_tick_d;
         col_spawn_q    <= col_spawn_d;
         col_clear_q    <= col_clear_d;
         spawn_letter_q <= spawn_letter_d;
         game_over_q    <= game_over_d;
      end

   assign fall_tick    = fall_tick_q;
   assign col_spawn    = col_spawn_q;
   assign spawn_letter = spawn_letter_q;
   assign col_clear    = col_clear_q;
   assign score        = score_q;
   assign level        = level_q;
   assign game_over    = game_over_q;
endmodule

// File: tb/tb_column_scheduler.sv
// tb_column_scheduler: randomized self-checking bench for column_scheduler with small timing parameters.
module tb_column_scheduler;
   localparam int N = 4;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, key_valid = 1'b0;
   logic [7:0] key_code = '0;
   logic [N-1:0] col_active = '0, col_landed = '0;
   logic [8*N-1:0] col_letter = '0;
   logic fall_tick, game_over;
   logic [N-1:0] col_spawn, col_clear;
   logic [7:0] spawn_letter;
   logic [9:0] score;
   logic [3:0] level;
   int checks = 0, errors = 0, mdl_score = 0, mdl_last = N - 1;
   logic [7:0] lfsr_m = 8'hA5, lfsr_p = 8'hA5;

   column_scheduler #(.NUM_COLUMNS(N), .BASE_PERIOD(10), .PERIOD_STEP(2), .MIN_PERIOD(4),
                      .SPAWN_TICKS(2), .POINTS_PER_LEVEL(2)) dut (
      .clock(clk), .reset_signal_n(rst_n), .start(start), .key_valid(key_valid), .key_code(key_code),
      .col_active(col_active), .col_landed(col_landed), .col_letter(col_letter), .fall_tick(fall_tick),
      .col_spawn(col_spawn), .spawn_letter(spawn_letter), .col_clear(col_clear), .score(score),
      .level(level), .game_over(game_over));

   always #5 clk = ~clk;

   // Reference letter source; lfsr_p is the state the DUT saw one cycle earlier.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         lfsr_m <= 8'hA5;
         lfsr_p <= 8'hA5;
      end else begin
         lfsr_p <= lfsr_m;
         lfsr_m <= {lfsr_m[6:0], ^(lfsr_m & 8'b1011_1000)};
      end

   function automatic logic [7:0] letter_of(logic [7:0] v);
      int x = int'(v[4:0]);
      if (x >= 26) x -= 26;
      return 8'(65 + x);
   endfunction

   function automatic int pick(int last, logic [N-1:0] fr);
      for (int k = 1; k <= N; k++) if (fr[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic int exp_period(int lv);
      int p = 10 - 2 * lv;
      return (p < 4) ? 4 : p;
   endfunction

   function automatic int exp_level(int s);
      return (s / 2 > 15) ? 15 : s / 2;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_tick(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (fall_tick === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      checks++; if ({fall_tick, col_spawn, col_clear, score, level, game_over} !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", {fall_tick, col_spawn, col_clear, score, level, game_over}); end
      checks++; if (spawn_letter !== 8'h41) begin errors++; $display("FAIL reset_letter got %h want 41", spawn_letter); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_start_spawn();
      logic [N-1:0] exp_sp;
      int p;
      pulse_start();
      checks++; if (col_clear !== 4'hF) begin errors++; $display("FAIL start_clear got %h want f", col_clear); end
      checks++; if (score !== 10'd0 || level !== 4'd0 || game_over !== 1'b0) begin errors++; $display("FAIL start_status got %0d/%0d/%b want 0/0/0", score, level, game_over); end
      for (int c = 1; c <= 85; c++) begin
         col_active = (c > 65) ? 4'hE : (c > 46) ? 4'hF : 4'h0;
         exp_sp = '0;
         if (c > 1 && c % 20 == 1) begin
            p = pick(mdl_last, ~col_active);
            if (p >= 0) begin
               exp_sp[p] = 1'b1;
               mdl_last = p;
            end
         end
         step();
         checks++; if (fall_tick !== (c % 10 == 0)) begin errors++; $display("FAIL tick_c%0d got %b want %b", c, fall_tick, c % 10 == 0); end
         checks++; if (col_spawn !== exp_sp) begin errors++; $display("FAIL spawn_c%0d got %b want %b", c, col_spawn, exp_sp); end
         if (exp_sp != 0) begin
            checks++; if (spawn_letter !== letter_of(lfsr_p) || spawn_letter < 8'h41 || spawn_letter > 8'h5A) begin errors++; $display("FAIL letter_c%0d got %h want %h", c, spawn_letter, letter_of(lfsr_p)); end
         end
      end
   endtask

   task automatic test_key_match();
      col_active = 4'b1010;
      col_letter = {"K", "Z", "K", "K"};
      key_code = "K";
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      mdl_score++;
      checks++; if (col_clear !== 4'b0010) begin errors++; $display("FAIL key_clear got %b want 0010", col_clear); end
      checks++; if (score !== 10'(mdl_score)) begin errors++; $display("FAIL key_score got %0d want %0d", score, mdl_score); end
      step();
      checks++; if (col_clear !== 4'b0000) begin errors++; $display("FAIL key_pulse got %b want 0000", col_clear); end
   endtask

   task automatic test_land();
      col_active = 4'b0100;
      col_letter = {"A", "Q", "B", "C"};
      col_landed = 4'b0100;
      key_code = "Q";
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      col_landed = '0;
      checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL land_over got %b want 1", game_over); end
      checks++; if (col_clear !== 4'b0000 || score !== 10'(mdl_score)) begin errors++; $display("FAIL land_noscore got %b/%0d want 0000/%0d", col_clear, score, mdl_score); end
      for (int c = 0; c < 25; c++) begin
         step();
         checks++; if (fall_tick !== 1'b0 || col_spawn !== '0 || game_over !== 1'b1) begin errors++; $display("FAIL over_idle_c%0d got %b/%b/%b want 0/0/1", c, fall_tick, col_spawn, game_over); end
      end
      pulse_start();
      mdl_score = 0;
      checks++; if (col_clear !== 4'hF || score !== 10'd0 || game_over !== 1'b0) begin errors++; $display("FAIL restart got %h/%0d/%b want f/0/0", col_clear, score, game_over); end
   endtask

   task automatic test_level_period();
      int n;
      pulse_start();
      checks++; if (col_clear !== 4'h0 || score !== 10'd0) begin errors++; $display("FAIL start_in_run got %h/%0d want 0/0", col_clear, score); end
      col_active = 4'b0001;
      col_letter = {"A", "B", "C", "M"};
      key_code = "M";
      key_valid = 1'b1;
      repeat (2) step();
      key_valid = 1'b0;
      mdl_score += 2;
      checks++; if (score !== 10'(mdl_score) || level !== 4'(exp_level(mdl_score))) begin errors++; $display("FAIL level1 got %0d/%0d want %0d/%0d", score, level, mdl_score, exp_level(mdl_score)); end
      wait_tick(n);
      wait_tick(n);
      checks++; if (n !== exp_period(exp_level(mdl_score))) begin errors++; $display("FAIL period_l1 got %0d want %0d", n, exp_period(exp_level(mdl_score))); end
      key_valid = 1'b1;
      repeat (10) step();
      key_valid = 1'b0;
      mdl_score += 10;
      checks++; if (score !== 10'(mdl_score) || level !== 4'(exp_level(mdl_score))) begin errors++; $display("FAIL level6 got %0d/%0d want %0d/%0d", score, level, mdl_score, exp_level(mdl_score)); end
      wait_tick(n);
      wait_tick(n);
      checks++; if (n !== exp_period(exp_level(mdl_score))) begin errors++; $display("FAIL period_min got %0d want %0d", n, exp_period(exp_level(mdl_score))); end
   endtask

   task automatic test_random_match();
      logic [N-1:0] exp_clr;
      for (int t = 0; t < 40; t++) begin
         col_active = N'($urandom);
         for (int i = 0; i < N; i++) col_letter[8*i +: 8] = 8'(65 + $urandom_range(0, 2));
         key_code = 8'(65 + $urandom_range(0, 3));
         key_valid = ($urandom_range(0, 3) != 0);
         exp_clr = '0;
         if (key_valid)
            for (int i = 0; i < N; i++)
               if (col_active[i] && col_letter[8*i +: 8] == key_code) begin
                  exp_clr[i] = 1'b1;
                  break;
               end
         if (exp_clr != 0 && mdl_score < 1023) mdl_score++;
         step();
         checks++; if (col_clear !== exp_clr) begin errors++; $display("FAIL rand_clear_t%0d got %b want %b", t, col_clear, exp_clr); end
         checks++; if (score !== 10'(mdl_score) || level !== 4'(exp_level(mdl_score))) begin errors++; $display("FAIL rand_score_t%0d got %0d/%0d want %0d/%0d", t, score, level, mdl_score, exp_level(mdl_score)); end
      end
      key_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({fall_tick, col_spawn, col_clear, score, level, game_over} !== '0 || spawn_letter !== 8'h41) begin errors++; $display("FAIL mid_reset got %h/%h want 0/41", {fall_tick, col_spawn, col_clear, score, level, game_over}, spawn_letter); end
      repeat (2) step();
      rst_n = 1'b1;
      col_active = 4'b0001;
      col_letter = {"A", "B", "C", "M"};
      key_code = "M";
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      checks++; if (col_clear !== 4'h0 || score !== 10'd0 || game_over !== 1'b0) begin errors++; $display("FAIL idle_key got %h/%0d/%b want 0/0/0", col_clear, score, game_over); end
      for (int c = 0; c < 15; c++) begin
         step();
         checks++; if (fall_tick !== 1'b0 || col_spawn !== '0) begin errors++; $display("FAIL idle_quiet_c%0d got %b/%b want 0/0", c, fall_tick, col_spawn); end
      end
      pulse_start();
      checks++; if (col_clear !== 4'hF) begin errors++; $display("FAIL start_after_reset got %h want f", col_clear); end
   endtask

   initial begin
      test_reset();
      test_start_spawn();
      test_key_match();
      test_land();
      test_level_period();
      test_random_match();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
